// File: rtl/if_id_stage_buffer.sv
// rtl/if_id_stage_buffer.sv - IF/ID pipeline stage buffer with valid/ready handshake, skid entry, flush and NOP bubbles
//
// Holds fetched instructions between the fetch stage (PC+4 adder, instruction
// memory) and decode. With SKID_EN=1 it is a two-entry buffer (main + skid)
// whose IN_READY is a flop, so no combinational path runs from OUT_READY back
// to fetch. With SKID_EN=0 it is a single register whose IN_READY is
// !OUT_VALID | OUT_READY.
//
// Ports:
//   CLK        in   1   clock, rising edge
//   RESET      in   1   synchronous, active-low reset
//   IN_VALID   in   1   fetch presents an instruction
//   IN_READY   out  1   stage can accept this cycle
//   IN_INSTR   in   IW  fetched instruction
//   IN_PC      in   AW  PC of fetched instruction
//   IN_PC4     in   AW  PC+4 of fetched instruction
//   FLUSH      in   1   redirect: discard every held entry
//   OUT_VALID  out  1   head entry valid
//   OUT_READY  in   1   decode consumes head this cycle
//   OUT_INSTR  out  IW  head instruction, NOP_INSTR while OUT_VALID=0
//   OUT_PC     out  AW  head PC (holds last value while empty)
//   OUT_PC4    out  AW  head PC+4 (holds last value while empty)
//   OCCUPANCY  out  2   number of valid entries, 0..2
//   FLUSH_CNT  out  CW  saturating count of entries discarded by FLUSH

module if_id_stage_buffer #(
    parameter int              IW        = 32,
    parameter int              AW        = 32,
    parameter int              SKID_EN   = 1,
    parameter logic [IW-1:0]   NOP_INSTR = IW'(32'h00000013),
    parameter logic [AW-1:0]   RESET_PC4 = {{(AW-2){1'b1}}, 2'b00},
    parameter int              CW        = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [IW-1:0] IN_INSTR,
    input  logic [AW-1:0] IN_PC,
    input  logic [AW-1:0] IN_PC4,
    input  logic          FLUSH,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [IW-1:0] OUT_INSTR,
    output logic [AW-1:0] OUT_PC,
    output logic [AW-1:0] OUT_PC4,
    output logic [1:0]    OCCUPANCY,
    output logic [CW-1:0] FLUSH_CNT
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [CW:0] CNT_MAX = {1'b0, {CW{1'b1}}};

    state_t        state;
    state_t        state_nxt;

    logic [IW-1:0] main_instr;
    logic [AW-1:0] main_pc;
    logic [AW-1:0] main_pc4;
    logic [IW-1:0] skid_instr;
    logic [AW-1:0] skid_pc;
    logic [AW-1:0] skid_pc4;
    logic [CW-1:0] flush_cnt;
    logic [CW-1:0] flush_cnt_nxt;

    logic          acc;
    logic          pop;
    logic          load_main_in;
    logic          load_main_skid;
    logic          load_skid;
    logic [1:0]    drop;
    logic [CW:0]   cnt_sum;

    assign OUT_VALID = (state != ST_EMPTY);
    assign acc       = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;

    // Ready generation: registered in the skid variant so that back-pressure
    // never closes a combinational loop through decode.
    generate
        if (SKID_EN != 0) begin : g_skid_ready
            logic in_ready_q;

            always_ff @(posedge CLK) begin
                if (!RESET) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_nxt != ST_SKID);
                end
            end

            assign IN_READY = in_ready_q;
        end else begin : g_comb_ready
            assign IN_READY = ~OUT_VALID | OUT_READY;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and payload-move selection. FLUSH wins over any handshake,
    // so an entry accepted in the same cycle is simply never loaded.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        case (state)
            ST_EMPTY: begin
                if (acc) begin
                    state_nxt    = ST_FULL;
                    load_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (acc && pop) begin
                    load_main_in = 1'b1;
                end else if (acc) begin
                    // Only reachable with SKID_EN=1: the combinational ready
                    // of the single-entry variant forbids acc without pop here.
                    state_nxt = ST_SKID;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (pop) begin
                    state_nxt      = ST_FULL;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase

        if (FLUSH) begin
            state_nxt      = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Payload registers. They are left untouched on pop/flush so OUT_PC and
    // OUT_PC4 keep their last value while the stage is empty.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            main_instr <= NOP_INSTR;
            main_pc    <= '0;
            main_pc4   <= RESET_PC4;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
            skid_pc4   <= RESET_PC4;
        end else begin
            if (load_main_in) begin
                main_instr <= IN_INSTR;
                main_pc    <= IN_PC;
                main_pc4   <= IN_PC4;
            end else if (load_main_skid) begin
                main_instr <= skid_instr;
                main_pc    <= skid_pc;
                main_pc4   <= skid_pc4;
            end
            if (load_skid) begin
                skid_instr <= IN_INSTR;
                skid_pc    <= IN_PC;
                skid_pc4   <= IN_PC4;
            end
        end
    end

    always_comb begin
        OCCUPANCY = 2'd0;
        case (state)
            ST_FULL: OCCUPANCY = 2'd1;
            ST_SKID: OCCUPANCY = 2'd2;
            default: OCCUPANCY = 2'd0;
        endcase
    end

    // An entry popped in the flush cycle was consumed by decode, so it is
    // not counted as discarded. pop implies OCCUPANCY>=1, so no underflow.
    always_comb begin
        drop          = OCCUPANCY - {1'b0, pop};
        cnt_sum       = {1'b0, flush_cnt} + (CW + 1)'(drop);
        flush_cnt_nxt = flush_cnt;
        if (FLUSH) begin
            if (cnt_sum > CNT_MAX) begin
                flush_cnt_nxt = CNT_MAX[CW-1:0];
            end else begin
                flush_cnt_nxt = cnt_sum[CW-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            flush_cnt <= '0;
        end else begin
            flush_cnt <= flush_cnt_nxt;
        end
    end

    assign FLUSH_CNT = flush_cnt;
    assign OUT_INSTR = OUT_VALID ? main_instr : NOP_INSTR;
    assign OUT_PC    = main_pc;
    assign OUT_PC4   = main_pc4;

endmodule

// File: tb/tb_if_id_stage_buffer.sv
// tb/tb_if_id_stage_buffer.sv - self-checking bench for if_id_stage_buffer, skid and single-entry variants

module tb_if_id_stage_buffer;

    logic        CLK;
    logic        RESET;
    logic        IN_VALID;
    logic [31:0] IN_INSTR;
    logic [31:0] IN_PC;
    logic [31:0] IN_PC4;
    logic        FLUSH;
    logic        OUT_READY;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_instr, s_out_pc, s_out_pc4;
    logic [1:0]  s_occ;
    logic [1:0]  s_fcnt;

    logic        n_in_ready, n_out_valid;
    logic [31:0] n_out_instr, n_out_pc, n_out_pc4;
    logic [1:0]  n_occ;
    logic [7:0]  n_fcnt;

    if_id_stage_buffer #(.SKID_EN(1), .CW(2)) dut_s (
        .CLK(CLK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(s_in_ready),
        .IN_INSTR(IN_INSTR), .IN_PC(IN_PC), .IN_PC4(IN_PC4),
        .FLUSH(FLUSH),
        .OUT_VALID(s_out_valid), .OUT_READY(OUT_READY),
        .OUT_INSTR(s_out_instr), .OUT_PC(s_out_pc), .OUT_PC4(s_out_pc4),
        .OCCUPANCY(s_occ), .FLUSH_CNT(s_fcnt)
    );

    if_id_stage_buffer #(.SKID_EN(0), .CW(8)) dut_n (
        .CLK(CLK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(n_in_ready),
        .IN_INSTR(IN_INSTR), .IN_PC(IN_PC), .IN_PC4(IN_PC4),
        .FLUSH(FLUSH),
        .OUT_VALID(n_out_valid), .OUT_READY(OUT_READY),
        .OUT_INSTR(n_out_instr), .OUT_PC(n_out_pc), .OUT_PC4(n_out_pc4),
        .OCCUPANCY(n_occ), .FLUSH_CNT(n_fcnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    // Reference model: index 0 = skid variant (capacity 2, counter cap 3),
    // index 1 = single-entry variant (capacity 1, counter cap 255).
    ent_t        m_ent [2][2];
    int          m_occ [2];
    int          m_cnt [2];
    int          m_cap [2];
    logic [31:0] m_lpc [2];
    logic [31:0] m_lpc4[2];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    function automatic bit exp_ready(input int k);
        if (k == 0) return (m_occ[0] < 2);
        return (m_occ[1] == 0) || OUT_READY;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit acc, pop;
        for (int k = 0; k < 2; k++) begin
            if (!RESET) begin
                m_occ[k]  = 0;
                m_cnt[k]  = 0;
                m_lpc[k]  = 32'h0;
                m_lpc4[k] = 32'hFFFF_FFFC;
            end else begin
                acc = IN_VALID && exp_ready(k);
                pop = (m_occ[k] > 0) && OUT_READY;
                if (FLUSH) begin
                    m_cnt[k] = m_cnt[k] + m_occ[k] - (pop ? 1 : 0);
                    if (m_cnt[k] > m_cap[k]) m_cnt[k] = m_cap[k];
                    m_occ[k] = 0;
                end else begin
                    if (pop) begin
                        m_ent[k][0] = m_ent[k][1];
                        m_occ[k]--;
                    end
                    if (acc) begin
                        m_ent[k][m_occ[k]] = '{IN_INSTR, IN_PC, IN_PC4};
                        m_occ[k]++;
                    end
                end
                if (m_occ[k] > 0) begin
                    m_lpc[k]  = m_ent[k][0].pc;
                    m_lpc4[k] = m_ent[k][0].pc4;
                end
            end
        end
    endtask

    task automatic compare_all();
        if (cmp_en) begin
            chk("s_valid",  32'(s_out_valid), 32'(m_occ[0] > 0));
            chk("s_instr",  s_out_instr, (m_occ[0] > 0) ? m_ent[0][0].instr : 32'h13);
            chk("s_pc",     s_out_pc,  m_lpc[0]);
            chk("s_pc4",    s_out_pc4, m_lpc4[0]);
            chk("s_occ",    32'(s_occ),  32'(m_occ[0]));
            chk("s_fcnt",   32'(s_fcnt), 32'(m_cnt[0]));
            chk("s_rdy",    32'(s_in_ready), 32'(exp_ready(0)));
            chk("n_valid",  32'(n_out_valid), 32'(m_occ[1] > 0));
            chk("n_instr",  n_out_instr, (m_occ[1] > 0) ? m_ent[1][0].instr : 32'h13);
            chk("n_pc",     n_out_pc,  m_lpc[1]);
            chk("n_pc4",    n_out_pc4, m_lpc4[1]);
            chk("n_occ",    32'(n_occ),  32'(m_occ[1]));
            chk("n_fcnt",   32'(n_fcnt), 32'(m_cnt[1]));
            chk("n_rdy",    32'(n_in_ready), 32'(exp_ready(1)));
        end
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model
    // at the rising edge, return just after it.
    task automatic cyc(input logic rst, input logic v, input logic fl, input logic ordy,
                       input logic [31:0] pc, input logic [31:0] instr);
        RESET     = rst;
        IN_VALID  = v;
        FLUSH     = fl;
        OUT_READY = ordy;
        IN_PC     = pc;
        IN_PC4    = pc + 32'd4;
        IN_INSTR  = instr;
        @(negedge CLK);
        compare_all();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic dcyc(input logic rst, input logic v, input logic fl, input logic ordy,
                        input logic [31:0] pc);
        cyc(rst, v, fl, ordy, pc, pc ^ 32'h1357_0013);
    endtask

    initial begin
        m_cap[0] = 3;
        m_cap[1] = 255;
        RESET = 1'b0; IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b0;
        IN_PC = '0; IN_PC4 = '0; IN_INSTR = '0;

        // reset, two cycles
        dcyc(0, 0, 0, 0, 0);
        dcyc(0, 0, 0, 0, 0);
        cmp_en = 1;
        chk("rst_valid", 32'(s_out_valid), 32'd0);
        chk("rst_instr", s_out_instr, 32'h0000_0013);
        chk("rst_pc4",   s_out_pc4,   32'hFFFF_FFFC);
        chk("rst_fcnt",  32'(s_fcnt), 32'd0);
        chk("rst_rdy",   32'(s_in_ready), 32'd1);

        // streaming: one-cycle latency, ready never drops
        for (int i = 0; i < 6; i++) begin
            dcyc(1, 1, 0, 1, 32'(4 * i));
            chk("strm_s_pc",  s_out_pc, 32'(4 * i));
            chk("strm_n_pc",  n_out_pc, 32'(4 * i));
            chk("strm_s_rdy", 32'(s_in_ready), 32'd1);
            chk("strm_n_rdy", 32'(n_in_ready), 32'd1);
        end
        dcyc(1, 0, 0, 1, 0);

        // back-pressure
        dcyc(1, 1, 0, 0, 32'd100);
        dcyc(1, 1, 0, 0, 32'd104);
        dcyc(1, 1, 0, 0, 32'd108);
        chk("bp_s_occ", 32'(s_occ), 32'd2);
        chk("bp_s_rdy", 32'(s_in_ready), 32'd0);
        chk("bp_s_pc",  s_out_pc, 32'd100);
        chk("bp_n_occ", 32'(n_occ), 32'd1);
        dcyc(1, 0, 0, 1, 0);
        chk("bp_rel_pc", s_out_pc, 32'd104);
        dcyc(1, 0, 0, 1, 0);
        chk("bp_rel_occ", 32'(s_occ), 32'd0);

        // flush with IN_VALID=1, OUT_READY=0
        dcyc(1, 1, 0, 0, 32'd200);
        dcyc(1, 1, 0, 0, 32'd204);
        dcyc(1, 1, 1, 0, 32'd208);
        chk("fl_occ",    32'(s_occ), 32'd0);
        chk("fl_instr",  s_out_instr, 32'h0000_0013);
        chk("fl_s_fcnt", 32'(s_fcnt), 32'd2);
        chk("fl_n_fcnt", 32'(n_fcnt), 32'd1);
        // flush drops a same-cycle accept; a same-cycle pop is not counted
        dcyc(1, 1, 1, 1, 32'd300);
        chk("fl_acc_occ", 32'(s_occ), 32'd0);
        dcyc(1, 1, 0, 0, 32'd400);
        dcyc(1, 0, 1, 1, 0);
        chk("fl_pop_fcnt", 32'(s_fcnt), 32'd2);

        // saturation of the 2-bit counter
        for (int i = 0; i < 4; i++) begin
            dcyc(1, 1, 0, 0, 32'(500 + 8 * i));
            dcyc(1, 1, 0, 0, 32'(504 + 8 * i));
            dcyc(1, 0, 1, 0, 0);
        end
        chk("sat_s_fcnt", 32'(s_fcnt), 32'd3);
        chk("sat_n_fcnt", 32'(n_fcnt), 32'd5);

        // reset in the middle of a flush with two entries held
        dcyc(1, 1, 0, 0, 32'd600);
        dcyc(1, 1, 0, 0, 32'd604);
        dcyc(0, 1, 1, 0, 32'd608);
        chk("mr_occ",   32'(s_occ), 32'd0);
        chk("mr_valid", 32'(s_out_valid), 32'd0);
        chk("mr_fcnt",  32'(s_fcnt), 32'd0);
        chk("mr_pc4",   s_out_pc4, 32'hFFFF_FFFC);
        chk("mr_rdy",   32'(s_in_ready), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 1) == 1),
                $urandom, $urandom);
        end
        dcyc(1, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
